// File: rtl/codec_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_pkg
//  Description : Shared types and constants for the WM8731 configuration
//                sequencer: FSM state encoding, codec register addresses and
//                the width of one I2C write word.
//  Revision    : 1.0  initial release
// ============================================================================
package codec_cfg_pkg;

    // One codec write is {dev_addr[6:0], r/w, reg_addr[6:0], reg_val[8:0]}
    localparam int I2C_WORD_W = 24;

    // WM8731 control register addresses
    localparam logic [6:0] C_WM_R0  = 7'h00;  // left line in
    localparam logic [6:0] C_WM_R1  = 7'h01;  // right line in
    localparam logic [6:0] C_WM_R2  = 7'h02;  // left headphone out
    localparam logic [6:0] C_WM_R3  = 7'h03;  // right headphone out
    localparam logic [6:0] C_WM_R4  = 7'h04;  // analogue path
    localparam logic [6:0] C_WM_R5  = 7'h05;  // digital path
    localparam logic [6:0] C_WM_R6  = 7'h06;  // power down
    localparam logic [6:0] C_WM_R7  = 7'h07;  // digital interface format
    localparam logic [6:0] C_WM_R8  = 7'h08;  // sampling control
    localparam logic [6:0] C_WM_R9  = 7'h09;  // active control
    localparam logic [6:0] C_WM_R15 = 7'h0F;  // reset register

    // Sequencer states. S_RGAP is the idle gap before re-sending a NACKed
    // entry; it is only reachable when retries are enabled.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_RGAP  = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/codec_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_sequencer_if
//  Description : Handshake between the configuration sequencer (master) and
//                the I2C transmitter (slave).
//                  i2c_start : one-cycle pulse, transmitter latches i2c_data
//                  i2c_data  : 24-bit write word
//                  i2c_busy  : transmitter mid-transfer
//                  i2c_done  : one-cycle pulse, transfer finished
//                  i2c_nack  : valid with i2c_done, 1 = a byte was not ACKed
//  Revision    : 1.0  initial release
// ============================================================================
interface codec_cfg_sequencer_if;
    import codec_cfg_pkg::*;

    logic                  i2c_start;
    logic [I2C_WORD_W-1:0] i2c_data;
    logic                  i2c_busy;
    logic                  i2c_done;
    logic                  i2c_nack;

    modport master (
        output i2c_start,
        output i2c_data,
        input  i2c_busy,
        input  i2c_done,
        input  i2c_nack
    );

    modport slave (
        input  i2c_start,
        input  i2c_data,
        output i2c_busy,
        output i2c_done,
        output i2c_nack
    );

endinterface
`default_nettype wire

// File: rtl/codec_reg_rom.sv
`default_nettype none
// ============================================================================
//  Module      : codec_reg_rom
//  Description : Combinational power-up register table for the WM8731.
//                Maps a table index to {reg_addr[6:0], reg_val[8:0]}.
//                Indices at or past NUM_REGS return 16'h0.
//  Ports       : i_index  table index
//                o_word   {reg_addr, reg_val}
//  Revision    : 1.0  initial release
// ============================================================================
module codec_reg_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS = 11,
    parameter int IDX_W    = 4
) (
    input  wire logic [IDX_W-1:0] i_index,
    output logic      [15:0]      o_word
);

    int unsigned w_sel;

    // The codec reset write goes first so later writes land on known state;
    // the activate write must stay last so the codec only starts once fully
    // configured.
    always_comb begin
        w_sel  = 32'(i_index);
        o_word = 16'h0;
        if (w_sel < 32'(NUM_REGS)) begin
            case (w_sel)
                0:       o_word = {C_WM_R15, 9'h000};
                1:       o_word = {C_WM_R0,  9'h017};
                2:       o_word = {C_WM_R1,  9'h017};
                3:       o_word = {C_WM_R2,  9'h079};
                4:       o_word = {C_WM_R3,  9'h079};
                5:       o_word = {C_WM_R4,  9'h012};
                6:       o_word = {C_WM_R5,  9'h000};
                7:       o_word = {C_WM_R6,  9'h000};
                8:       o_word = {C_WM_R7,  9'h042};  // I2S, 16 bit, master
                9:       o_word = {C_WM_R8,  9'h000};
                10:      o_word = {C_WM_R9,  9'h001};  // active
                default: o_word = 16'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/codec_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : codec_cfg_sequencer
//  Description : Power-up configuration controller for the WM8731 codec.
//                Walks the register table, issues one 24-bit write per entry
//                to the I2C transmitter, waits for completion, leaves a
//                bus-free gap between writes and finally raises ready.
//  Ports       : clk, reset (sync, active high), start (1-cycle pulse)
//                i2c       : master side of codec_cfg_sequencer_if
//                ready     : table fully written, held until reset/start
//                error     : configuration aborted, held until reset/start
//                cur_index : entry in flight
//  Options     : CFG_RETRY_EN - when defined, a NACKed entry is re-sent up to
//                MAX_RETRY times before aborting; otherwise the first NACK
//                aborts and no retry counter exists.
//  Revision    : 1.0  initial release
// ============================================================================
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_REGS   = 11,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         GAP_CYCLES = 16,
    parameter int         MAX_RETRY  = 3
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    codec_cfg_sequencer_if.master      i2c,
    output logic                       ready,
    output logic                       error,
    output logic [3:0]                 cur_index
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // The gap and retry counters share one width, sized for the larger count
    localparam int CNT_W = $clog2(((GAP_CYCLES > MAX_RETRY) ? GAP_CYCLES : MAX_RETRY) + 1);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    seq_state_t            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_gap_cnt;
    logic                  r_i2c_start;
    logic [I2C_WORD_W-1:0] r_i2c_data;
    logic                  r_ready;
    logic                  r_error;
`ifdef CFG_RETRY_EN
    localparam logic [CNT_W-1:0] C_MAX_RETRY = CNT_W'(MAX_RETRY);
    logic [CNT_W-1:0]      r_retry;
    logic                  w_retry_inc;
    logic                  w_retry_clr;
`endif

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    seq_state_t            w_next_state;
    logic                  w_load;
    logic                  w_fire;
    logic                  w_gap_clr;
    logic                  w_gap_last;
    logic                  w_in_gap;
    logic                  w_idx_clr;
    logic                  w_idx_inc;
    logic                  w_set_ready;
    logic                  w_set_error;
    logic                  w_clr_flags;
    logic [15:0]           w_rom_word;

    codec_reg_rom #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_rom (
        .i_index  (r_idx),
        .o_word   (w_rom_word)
    );

    assign w_in_gap   = (r_state == S_GAP) || (r_state == S_RGAP);
    assign w_gap_last = (r_gap_cnt == C_GAP_LAST);

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_fire       = 1'b0;
        w_gap_clr    = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_set_ready  = 1'b0;
        w_set_error  = 1'b0;
        w_clr_flags  = 1'b0;
`ifdef CFG_RETRY_EN
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx_clr    = 1'b1;
`ifdef CFG_RETRY_EN
                    w_retry_clr  = 1'b1;
`endif
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_next_state = S_SEND;
            end
            S_SEND: begin
                // Never start over a transfer the transmitter still owns
                if (!i2c.i2c_busy) begin
                    w_fire       = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c.i2c_done) begin
                    w_gap_clr = 1'b1;
                    if (!i2c.i2c_nack) begin
`ifdef CFG_RETRY_EN
                        w_retry_clr  = 1'b1;
`endif
                        w_next_state = S_GAP;
                    end
`ifdef CFG_RETRY_EN
                    else if (r_retry < C_MAX_RETRY) begin
                        w_retry_inc  = 1'b1;
                        w_next_state = S_RGAP;
                    end
`endif
                    else begin
                        w_set_error  = 1'b1;
                        w_next_state = S_ERROR;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_set_ready  = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_next_state = S_LOAD;
                    end
                end
            end
            S_RGAP: begin
                // i2c_data still holds the failed entry, so skip LOAD
                if (w_gap_last) begin
                    w_next_state = S_SEND;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    w_clr_flags  = 1'b1;
                    w_idx_clr    = 1'b1;
`ifdef CFG_RETRY_EN
                    w_retry_clr  = 1'b1;
`endif
                    w_next_state = S_LOAD;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_i2c_start <= 1'b0;
            r_i2c_data  <= '0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_i2c_start <= w_fire;

            if (w_load) begin
                r_i2c_data <= {DEV_ADDR, 1'b0, w_rom_word};
            end

            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc && (r_idx != C_LAST_IDX)) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (w_in_gap && !w_gap_last) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            if (w_clr_flags) begin
                r_ready <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_set_ready) begin
                r_ready <= 1'b1;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

`ifdef CFG_RETRY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry <= '0;
        end else if (w_retry_clr) begin
            r_retry <= '0;
        end else if (w_retry_inc) begin
            r_retry <= r_retry + 1'b1;
        end
    end
`endif

    assign i2c.i2c_start = r_i2c_start;
    assign i2c.i2c_data  = r_i2c_data;
    assign ready         = r_ready;
    assign error         = r_error;
    assign cur_index     = 4'(r_idx);

endmodule
`default_nettype wire

// File: tb/tb_codec_cfg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_codec_cfg_sequencer
//  Description : Self-checking bench for codec_cfg_sequencer. A deadline-based
//                reference model predicts every output each cycle; a simple
//                transmitter model answers the I2C handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_codec_cfg_sequencer;

    localparam int NUM_REGS = 11;
    localparam int GAP      = 16;
    localparam int MAXR     = 3;
    localparam int TX_BUSY  = 27;
`ifdef CFG_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ready, error;
    logic [3:0] cur_index;

    codec_cfg_sequencer_if bus();

    logic tx_busy    = 1'b0;
    logic force_busy = 1'b0;
    logic tx_done    = 1'b0;
    logic tx_nack    = 1'b0;
    assign bus.i2c_busy = tx_busy | force_busy;
    assign bus.i2c_done = tx_done;
    assign bus.i2c_nack = tx_nack;

    codec_cfg_sequencer #(
        .NUM_REGS   (NUM_REGS),
        .DEV_ADDR   (7'h1A),
        .GAP_CYCLES (GAP),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .i2c       (bus),
        .ready     (ready),
        .error     (error),
        .cur_index (cur_index)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected write word for each table position, built from register/value pairs
    function automatic logic [23:0] exp_word(input int i);
        logic [6:0] a;
        logic [8:0] v;
        case (i)
            0:  begin a = 7'd15; v = 9'h000; end
            1:  begin a = 7'd0;  v = 9'h017; end
            2:  begin a = 7'd1;  v = 9'h017; end
            3:  begin a = 7'd2;  v = 9'h079; end
            4:  begin a = 7'd3;  v = 9'h079; end
            5:  begin a = 7'd4;  v = 9'h012; end
            6:  begin a = 7'd5;  v = 9'h000; end
            7:  begin a = 7'd6;  v = 9'h000; end
            8:  begin a = 7'd7;  v = 9'h042; end
            9:  begin a = 7'd8;  v = 9'h000; end
            default: begin a = 7'd9; v = 9'h001; end
        endcase
        return {7'h1A, 1'b0, a, v};
    endfunction

    // ------------------------------------------------------------------
    // Transmitter model
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [23:0] sent_q[$];
    int          n_done = 0;
    int          last_start_cyc = 0;
    int          last_done_cyc = 0;
    int          tx_cnt = 0;
    logic [23:0] tx_word = '0;
    int          nack_mode = 0;   // 0 ack all, 1 nack word always, 2 nack word once, 3 random
    logic [23:0] nack_word = '0;
    bit          nacked_once = 1'b0;
    int          nack_pct = 0;

    function automatic logic decide_nack(input logic [23:0] w);
        case (nack_mode)
            1: return (w == nack_word);
            2: if (w == nack_word && !nacked_once) begin
                   nacked_once = 1'b1;
                   return 1'b1;
               end else return 1'b0;
            3: return ($urandom_range(0, 99) < nack_pct);
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        tx_done = 1'b0;
        tx_nack = 1'b0;
        if (bus.i2c_start === 1'b1) begin
            tx_busy = 1'b1;
            tx_cnt  = TX_BUSY;
            tx_word = bus.i2c_data;
            sent_q.push_back(tx_word);
            last_start_cyc = cyc;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
                tx_nack = decide_nack(tx_word);
                n_done++;
                last_done_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: tracks the next deadline (start due, gap end)
    // rather than the design's internal states.
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_ARMED, M_FLIGHT, M_HOLD, M_FIN, M_ABORT} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_due = 0, m_end = 0, m_idx = 0, m_retry = 0;
    bit          m_resend = 1'b0;
    logic        e_start = 1'b0, e_ready = 1'b0, e_error = 1'b0;
    logic [23:0] e_data = '0;
    logic [3:0]  e_idx = '0;

    task automatic arm_from_zero();
        m_idx    = 0;
        e_idx    = 4'd0;
        m_retry  = 0;
        m_resend = 1'b0;
        m_due    = cyc + 2;   // load next edge, start pulse the edge after
        m_mode   = M_ARMED;
    endtask

    always @(posedge clk) begin
        cyc++;
        e_start = 1'b0;
        if (reset) begin
            m_mode  = M_IDLE;
            e_data  = '0;
            e_ready = 1'b0;
            e_error = 1'b0;
            e_idx   = 4'd0;
            m_idx   = 0;
            m_retry = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) arm_from_zero();
                M_ARMED: begin
                    if (!m_resend && cyc == m_due - 1) e_data = exp_word(m_idx);
                    if (cyc >= m_due && !bus.i2c_busy) begin
                        e_start = 1'b1;
                        m_mode  = M_FLIGHT;
                    end
                end
                M_FLIGHT: if (bus.i2c_done) begin
                    if (!bus.i2c_nack) begin
                        m_retry = 0; m_resend = 1'b0; m_end = cyc + GAP; m_mode = M_HOLD;
                    end else if (RETRY_EN && m_retry < MAXR) begin
                        m_retry++; m_resend = 1'b1; m_end = cyc + GAP; m_mode = M_HOLD;
                    end else begin
                        e_error = 1'b1; m_mode = M_ABORT;
                    end
                end
                M_HOLD: if (cyc == m_end) begin
                    if (m_resend) begin
                        m_due = cyc + 1; m_mode = M_ARMED;
                    end else if (m_idx == NUM_REGS - 1) begin
                        e_ready = 1'b1; m_mode = M_FIN;
                    end else begin
                        m_idx++; e_idx = 4'(m_idx); m_due = cyc + 2; m_mode = M_ARMED;
                    end
                end
                M_FIN, M_ABORT: if (start) begin
                    e_ready = 1'b0; e_error = 1'b0; arm_from_zero();
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_i2c_start", 32'(bus.i2c_start), 32'(e_start));
            check("cyc_i2c_data",  32'(bus.i2c_data),  32'(e_data));
            check("cyc_ready",     32'(ready),         32'(e_ready));
            check("cyc_error",     32'(error),         32'(e_error));
            check("cyc_cur_index", 32'(cur_index),     32'(e_idx));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int start_drive_cyc = 0;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_drive_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int k = 0;
        while (!(ready === 1'b1 || error === 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_sends(input string name, input int n, input int budget);
        int k = 0;
        while (sent_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < budget), 32'd1);
    endtask

    function automatic int count_word(input logic [23:0] w);
        int c = 0;
        foreach (sent_q[i]) if (sent_q[i] == w) c++;
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int ready_cyc;
        int first_lat;
        int n_before;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready",     32'(ready),         32'd0);
        check("rst_error",     32'(error),         32'd0);
        check("rst_i2c_start", 32'(bus.i2c_start), 32'd0);
        check("rst_i2c_data",  32'(bus.i2c_data),  32'd0);
        check("rst_cur_index", 32'(cur_index),     32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1. full sequence, all ACKed
        sent_q.delete();
        pulse_start();
        wait_sends("t1_first_send", 1, 100);
        // start is sampled one edge after driving, then two edges to i2c_start
        first_lat = last_start_cyc - start_drive_cyc;
        check("t1_first_latency", 32'(first_lat), 32'd3);
        ready_cyc = 0;
        begin
            int k = 0;
            while (ready !== 1'b1 && error !== 1'b1 && k < 3000) begin
                @(negedge clk);
                k++;
            end
            ready_cyc = cyc;
            check("t1_timeout", 32'(k < 3000), 32'd1);
        end
        check("t1_sends",       32'(sent_q.size()), 32'd11);
        check("t1_first_word",  32'(sent_q[0]), 32'h341E00);
        check("t1_last_word",   32'(sent_q[sent_q.size()-1]), 32'h341201);
        check("t1_ready",       32'(ready), 32'd1);
        check("t1_error",       32'(error), 32'd0);
        check("t1_ready_delay", 32'(ready_cyc - last_done_cyc), 32'(GAP + 1));

        // 2. entry 4 NACKed on its first attempt only
        sent_q.delete();
        nack_mode = 2; nack_word = exp_word(4); nacked_once = 1'b0;
        pulse_start();
        wait_end("t2_timeout", 3000);
`ifdef CFG_RETRY_EN
        check("t2_entry4_sends", 32'(count_word(exp_word(4))), 32'd2);
        check("t2_sends",        32'(sent_q.size()), 32'd12);
        check("t2_ready",        32'(ready), 32'd1);
        check("t2_error",        32'(error), 32'd0);
`else
        check("t2_error",        32'(error), 32'd1);
        check("t2_ready",        32'(ready), 32'd0);
        check("t2_cur_index",    32'(cur_index), 32'd4);
        check("t2_sends",        32'(sent_q.size()), 32'd5);
`endif

        // 3. R2 write NACKed every time
        sent_q.delete();
        nack_mode = 1; nack_word = 24'h340479;
        pulse_start();
        wait_end("t3_timeout", 3000);
        check("t3_error", 32'(error), 32'd1);
        check("t3_ready", 32'(ready), 32'd0);
`ifdef CFG_RETRY_EN
        check("t3_r2_sends", 32'(count_word(24'h340479)), 32'd4);
`else
        check("t3_r2_sends", 32'(count_word(24'h340479)), 32'd1);
`endif

        // 4. reset during the transfer of entry 6
        nack_mode = 0;
        sent_q.delete();
        pulse_start();
        wait_sends("t4_reach_entry6", 7, 3000);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_ready",     32'(ready),         32'd0);
        check("t4_error",     32'(error),         32'd0);
        check("t4_i2c_start", 32'(bus.i2c_start), 32'd0);
        check("t4_i2c_data",  32'(bus.i2c_data),  32'd0);
        check("t4_cur_index", 32'(cur_index),     32'd0);
        n_before = n_done;
        begin
            int k = 0;
            while (n_done == n_before && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("t4_stale_done_seen", 32'(k < 100), 32'd1);
        end
        repeat (4) @(negedge clk);
        check("t4_idle_sends",     32'(sent_q.size()), 32'd7);
        check("t4_idle_cur_index", 32'(cur_index), 32'd0);
        sent_q.delete();
        pulse_start();
        wait_sends("t4_resend", 1, 100);
        check("t4_resend_word", 32'(sent_q[0]), 32'h341E00);
        wait_end("t4_timeout", 3000);

        // 5. start during a gap is ignored; start in DONE restarts
        check("t5_ready_before", 32'(ready), 32'd1);
        sent_q.delete();
        pulse_start();
        check("t5_ready_dropped", 32'(ready), 32'd0);
        n_before = n_done;
        begin
            int k = 0;
            while (n_done < n_before + 2 && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("t5_reach_gap", 32'(k < 500), 32'd1);
        end
        repeat (3) @(negedge clk);
        pulse_start();
        wait_end("t5_timeout", 3000);
        check("t5_sends", 32'(sent_q.size()), 32'd11);
        check("t5_ready", 32'(ready), 32'd1);

        // 6. transmitter busy when SEND is entered
        sent_q.delete();
        force_busy = 1'b1;
        pulse_start();
        repeat (50) @(negedge clk);
        check("t6_held_sends", 32'(sent_q.size()), 32'd0);
        force_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_one_send", 32'(sent_q.size()), 32'd1);
        wait_end("t6_timeout", 3000);

        // 7. randomized: random NACKs, stray start pulses, busy blips
        nack_mode = 3; nack_pct = 15;
        for (int run = 0; run < 6; run++) begin
            pulse_start();
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(10, 150)) @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    pulse_start();
                end else begin
                    force_busy = 1'b1;
                    repeat ($urandom_range(1, 40)) @(negedge clk);
                    force_busy = 1'b0;
                end
            end
            wait_end("t7_timeout", 4000);
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
